// File: rtl/serial_add_arbiter.sv
// Round-robin arbiter that shares one registered 1-bit full adder between two
// requesters and runs WIDTH-bit additions bit-serially, LSB first.
module serial_add_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [1:0]         req_cin,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   res_sum,
  output logic               res_cout,
  output logic               res_id,
  output logic               busy,
  output logic               fa_x1,
  output logic               fa_x2,
  output logic               fa_cin,
  input  logic               fa_s,
  input  logic               fa_c
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             op_id;
  logic [WIDTH-2:0] sum_q;
  logic [IW-1:0]    bit_idx;
  logic [IW-1:0]    idx_m1;
  logic             last_grant;
  logic             gnt_any;
  logic             gnt_id;

  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = 1'b0;
    if (state == IDLE) begin
      unique case (req_valid)
        2'b01:   begin gnt_any = 1'b1; gnt_id = 1'b0;        end
        2'b10:   begin gnt_any = 1'b1; gnt_id = 1'b1;        end
        2'b11:   begin gnt_any = 1'b1; gnt_id = ~last_grant; end
        default: begin gnt_any = 1'b0; gnt_id = 1'b0;        end
      endcase
    end
    req_ready = '0;
    if (gnt_any) req_ready[gnt_id] = 1'b1;
  end

  // Bit 0 takes the latched carry so the adder's unreset carry is never consumed.
  always_comb begin
    fa_x1  = 1'b0;
    fa_x2  = 1'b0;
    fa_cin = 1'b0;
    if (state == ISSUE) begin
      fa_x1  = op_a[bit_idx];
      fa_x2  = op_b[bit_idx];
      fa_cin = (bit_idx == '0) ? op_cin : fa_c;
    end
  end

  assign busy   = (state != IDLE);
  assign idx_m1 = bit_idx - IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      res_valid  <= 1'b0;
      res_sum    <= '0;
      res_cout   <= 1'b0;
      res_id     <= 1'b0;
      last_grant <= 1'b1;
      bit_idx    <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_cin     <= 1'b0;
      op_id      <= 1'b0;
      sum_q      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_any) begin
            op_a       <= gnt_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
            op_b       <= gnt_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
            op_cin     <= req_cin[gnt_id];
            op_id      <= gnt_id;
            last_grant <= gnt_id;
            bit_idx    <= '0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // Adder output lags issue by one cycle, so it belongs to the previous bit.
          if (bit_idx != '0) sum_q[idx_m1] <= fa_s;
          if (bit_idx == LAST_IDX) begin
            bit_idx <= '0;
            state   <= DRAIN;
          end else begin
            bit_idx <= bit_idx + IW'(1);
          end
        end
        DRAIN: begin
          res_sum   <= {fa_s, sum_q};
          res_cout  <= fa_c;
          res_id    <= op_id;
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Directed bench for serial_add_arbiter with a behavioural registered full adder.
module tb_serial_add_arbiter;

  localparam int WIDTH = 8;

  logic               clk;
  logic               rst_n;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [1:0]         req_cin;
  logic               res_valid;
  logic               res_ready;
  logic [WIDTH-1:0]   res_sum;
  logic               res_cout;
  logic               res_id;
  logic               busy;
  logic               fa_x1;
  logic               fa_x2;
  logic               fa_cin;
  logic               fa_s;
  logic               fa_c;

  int nerr = 0;
  int nchk = 0;

  serial_add_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id),
    .busy(busy),
    .fa_x1(fa_x1), .fa_x2(fa_x2), .fa_cin(fa_cin),
    .fa_s(fa_s), .fa_c(fa_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered full adder, no reset
  always @(posedge clk)
    {fa_c, fa_s} <= {1'b0, fa_x1} + {1'b0, fa_x2} + {1'b0, fa_cin};

  // Called just after a negedge with the DUT in IDLE; returns just after the
  // negedge where the DUT is IDLE again.
  task automatic op(input string nm, input logic [1:0] v, input logic [1:0] v_after,
                    input logic [7:0] a0, input logic [7:0] b0,
                    input logic [7:0] a1, input logic [7:0] b1,
                    input logic [1:0] cin, input logic g,
                    input logic [7:0] es, input logic ec, input int hold);
    logic [1:0] exp_rdy;
    logic [7:0] oa, ob;
    logic       car;
    exp_rdy   = g ? 2'b10 : 2'b01;
    oa        = g ? a1 : a0;
    ob        = g ? b1 : b0;
    car       = cin[g];
    req_valid = v;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    req_cin   = cin;
    res_ready = 1'b0;
    #1;
    nchk++;
    if (req_ready !== exp_rdy) begin
      nerr++; $display("FAIL %s grant: req_ready=%b want %b", nm, req_ready, exp_rdy);
    end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = v_after;
        req_a     = ~req_a;
        req_b     = ~req_b;
        req_cin   = ~req_cin;
      end
      #1;
      nchk++;
      if (req_ready !== 2'b00 || busy !== 1'b1) begin
        nerr++; $display("FAIL %s busy k=%0d: req_ready=%b busy=%b want 00/1", nm, k, req_ready, busy);
      end
      nchk++;
      if (k <= 8) begin
        if (fa_x1 !== oa[k-1] || fa_x2 !== ob[k-1] || fa_cin !== car || (k > 1 && fa_cin !== fa_c)) begin
          nerr++; $display("FAIL %s issue bit %0d: x1=%b x2=%b cin=%b fa_c=%b want %b %b %b",
                           nm, k-1, fa_x1, fa_x2, fa_cin, fa_c, oa[k-1], ob[k-1], car);
        end
        car = (oa[k-1] & ob[k-1]) | (car & (oa[k-1] ^ ob[k-1]));
      end else if ({fa_x1, fa_x2, fa_cin} !== 3'b000) begin
        nerr++; $display("FAIL %s fa idle k=%0d: %b want 000", nm, k, {fa_x1, fa_x2, fa_cin});
      end
      nchk++;
      if (k < 10) begin
        if (res_valid !== 1'b0) begin
          nerr++; $display("FAIL %s early valid k=%0d: res_valid=%b want 0", nm, k, res_valid);
        end
      end else if (res_valid !== 1'b1 || res_sum !== es || res_cout !== ec || res_id !== g) begin
        nerr++; $display("FAIL %s result: valid=%b sum=%h cout=%b id=%b want 1 %h %b %b",
                         nm, res_valid, res_sum, res_cout, res_id, es, ec, g);
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      nchk++;
      if (res_valid !== 1'b1 || res_sum !== es || res_cout !== ec || res_id !== g || req_ready !== 2'b00) begin
        nerr++; $display("FAIL %s hold %0d: valid=%b sum=%h cout=%b id=%b rdy=%b want 1 %h %b %b 00",
                         nm, h, res_valid, res_sum, res_cout, res_id, req_ready, es, ec, g);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    nchk++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      nerr++; $display("FAIL %s accept: res_valid=%b busy=%b want 0/0", nm, res_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b00; req_a = '0; req_b = '0; req_cin = 2'b00; res_ready = 1'b0;
    #3;
    nchk++;
    if (res_valid !== 1'b0 || res_sum !== 8'h00 || res_cout !== 1'b0 || res_id !== 1'b0 ||
        busy !== 1'b0 || req_ready !== 2'b00 || {fa_x1, fa_x2, fa_cin} !== 3'b000) begin
      nerr++; $display("FAIL reset: valid=%b sum=%h cout=%b id=%b busy=%b rdy=%b fa=%b want all 0",
                       res_valid, res_sum, res_cout, res_id, busy, req_ready, {fa_x1, fa_x2, fa_cin});
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    nchk++;
    if (busy !== 1'b0 || req_ready !== 2'b00) begin
      nerr++; $display("FAIL idle_noreq: busy=%b rdy=%b want 0 00", busy, req_ready);
    end
  endtask

  task automatic test_single();
    op("single", 2'b01, 2'b00, 8'hA5, 8'h3C, 8'h00, 8'h00, 2'b00, 1'b0, 8'hE1, 1'b0, 0);
  endtask

  task automatic test_carry();
    op("ff_01",  2'b10, 2'b00, 8'h00, 8'h00, 8'hFF, 8'h01, 2'b00, 1'b1, 8'h00, 1'b1, 0);
    op("00_cin", 2'b01, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b01, 1'b0, 8'h01, 1'b0, 0);
    op("ff_ff",  2'b10, 2'b00, 8'h00, 8'h00, 8'hFF, 8'hFF, 2'b10, 1'b1, 8'hFF, 1'b1, 0);
  endtask

  task automatic test_round_robin();
    op("rr0", 2'b11, 2'b11, 8'h11, 8'h22, 8'h80, 8'h90, 2'b10, 1'b0, 8'h33, 1'b0, 0);
    op("rr1", 2'b11, 2'b11, 8'h11, 8'h22, 8'h80, 8'h90, 2'b10, 1'b1, 8'h11, 1'b1, 0);
    op("rr2", 2'b11, 2'b11, 8'h7F, 8'h01, 8'h80, 8'h90, 2'b10, 1'b0, 8'h80, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    op("bp",       2'b01, 2'b11, 8'h0F, 8'hF0, 8'h55, 8'h55, 2'b01, 1'b0, 8'h00, 1'b1, 5);
    op("bp_next",  2'b11, 2'b00, 8'h0F, 8'hF0, 8'h55, 8'h55, 2'b00, 1'b1, 8'hAA, 1'b0, 0);
  endtask

  task automatic test_mid_reset();
    req_valid = 2'b01; req_a = {8'h00, 8'h33}; req_b = {8'h00, 8'h44}; req_cin = 2'b00;
    res_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      req_valid = 2'b00;
    end
    #2;
    rst_n = 1'b0;
    #1;
    nchk++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || req_ready !== 2'b00 || res_sum !== 8'h00 ||
        {fa_x1, fa_x2, fa_cin} !== 3'b000) begin
      nerr++; $display("FAIL midreset: busy=%b valid=%b rdy=%b sum=%h fa=%b want 0 0 00 00 000",
                       busy, res_valid, req_ready, res_sum, {fa_x1, fa_x2, fa_cin});
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #1;
      nchk++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
        nerr++; $display("FAIL midreset ghost k=%0d: valid=%b busy=%b want 0 0", k, res_valid, busy);
      end
    end
    op("after_rst", 2'b01, 2'b00, 8'h12, 8'h34, 8'h00, 8'h00, 2'b00, 1'b0, 8'h46, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_round_robin();
    test_backpressure();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
